// File: rtl/drive_pkg.sv
// ----------------------------------------------------------------------------
// drive_pkg
//   Shared types and constants for the drive move controller.
//   - state_t        : move sequencer states
//   - done_status_t  : completion codes reported with the done pulse
//   - SPEED_W        : width of the motor speed bus (0..127, PWM period 100)
// ----------------------------------------------------------------------------
package drive_pkg;

  localparam int SPEED_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_RAMP_UP   = 3'd2,
    ST_CRUISE    = 3'd3,
    ST_RAMP_DOWN = 3'd4,
    ST_DONE      = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    DS_REACHED = 2'd0,
    DS_ABORTED = 2'd1,
    DS_STALLED = 2'd2
  } done_status_t;

endpackage

// File: rtl/speed_ramp.sv
// ----------------------------------------------------------------------------
// speed_ramp
//   Motor speed register with a step-interval tick counter. The sequencer
//   tells it what to do each cycle; it owns the speed value and the timing
//   of the +1/-1 steps.
//
//   i_clk       : clock, rising edge
//   i_rst_n     : synchronous active-low reset (speed 0, counter 0)
//   i_zero      : force speed to 0 (highest priority)
//   i_load_min  : load MIN_SPEED and restart the step interval
//   i_up        : count the interval, step +1 on expiry while below ceiling
//   i_down      : count the interval, step -1 on expiry while above MIN_SPEED
//   i_ceiling   : upper limit for up-steps (latched cruise speed)
//   o_speed     : registered motor speed
// ----------------------------------------------------------------------------
module speed_ramp
  import drive_pkg::*;
#(
  parameter int RAMP_TICKS = 500000,
  parameter int MIN_SPEED  = 10
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_zero,
  input  logic               i_load_min,
  input  logic               i_up,
  input  logic               i_down,
  input  logic [SPEED_W-1:0] i_ceiling,
  output logic [SPEED_W-1:0] o_speed
);

  logic [31:0]        r_tick_cnt;
  logic [SPEED_W-1:0] r_speed;
  logic               w_tick;

  assign w_tick  = (r_tick_cnt == 32'(RAMP_TICKS - 1));
  assign o_speed = r_speed;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tick_cnt <= '0;
      r_speed    <= '0;
    end else if (i_zero) begin
      r_tick_cnt <= '0;
      r_speed    <= '0;
    end else if (i_load_min) begin
      r_tick_cnt <= '0;
      r_speed    <= SPEED_W'(MIN_SPEED);
    end else if (i_up || i_down) begin
      if (w_tick) begin
        r_tick_cnt <= '0;
        if (i_up && (r_speed < i_ceiling))
          r_speed <= r_speed + 1'b1;
        else if (i_down && (r_speed > SPEED_W'(MIN_SPEED)))
          r_speed <= r_speed - 1'b1;
      end else begin
        r_tick_cnt <= r_tick_cnt + 32'd1;
      end
    end else begin
      // Not ramping: keep the interval parked at zero so the next ramp
      // state always starts with a full interval.
      r_tick_cnt <= '0;
    end
  end

endmodule

// File: rtl/drive_move_controller.sv
// ----------------------------------------------------------------------------
// drive_move_controller
//   Sequences one closed-loop straight move: accept a command, pulse the
//   encoder reset, ramp speed up to cruise, ramp down near the target and
//   stop on target reached, abort or encoder stall.
//
//   CLOCK_50        : system clock, rising edge
//   rst_n           : synchronous active-low reset
//   cmd_valid/ready : command handshake (ready only in IDLE)
//   cmd_distance_cm : target distance in cm
//   cmd_speed       : requested cruise speed (clamped to MIN..MAX)
//   cmd_dir         : direction, latched for the move
//   abort           : level, stops an active move
//   fault_clr       : pulse, leaves FAULT
//   encoder_cm      : signed distance from the Drive block
//   motor_speed     : speed command to the Drive block
//   motor_dir       : direction to the Drive block
//   encoder_reset   : encoder clear to the Drive block
//   busy            : any state other than IDLE
//   done            : one-cycle pulse at end of move
//   done_status     : 0 reached, 1 aborted, 2 stalled (held until next done)
//   fault           : high while in FAULT
// ----------------------------------------------------------------------------
module drive_move_controller
  import drive_pkg::*;
#(
  parameter int RAMP_TICKS   = 500000,
  parameter int DECEL_CM     = 20,
  parameter int MIN_SPEED    = 10,
  parameter int MAX_SPEED    = 100,
  parameter int STALL_TICKS  = 50000000,
  parameter int CLEAR_CYCLES = 4
) (
  input  logic                CLOCK_50,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [15:0]         cmd_distance_cm,
  input  logic [SPEED_W-1:0]  cmd_speed,
  input  logic                cmd_dir,
  input  logic                abort,
  input  logic                fault_clr,
  input  logic signed [31:0]  encoder_cm,
  output logic [SPEED_W-1:0]  motor_speed,
  output logic                motor_dir,
  output logic                encoder_reset,
  output logic                busy,
  output logic                done,
  output logic [1:0]          done_status,
  output logic                fault
);

  // |encoder_cm| saturated to 16 bits; the 33-bit magnitude keeps -2^31 exact.
  function automatic logic [15:0] sat_dist(input logic signed [31:0] enc);
    logic [32:0] mag;
    mag = enc[31] ? (33'd0 - {1'b1, enc}) : {1'b0, enc};
    return (mag >= 33'd65535) ? 16'hFFFF : mag[15:0];
  endfunction

  function automatic logic [SPEED_W-1:0] clamp_speed(input logic [SPEED_W-1:0] s);
    if (s < SPEED_W'(MIN_SPEED))
      return SPEED_W'(MIN_SPEED);
    else if (s > SPEED_W'(MAX_SPEED))
      return SPEED_W'(MAX_SPEED);
    else
      return s;
  endfunction

  state_t             r_state;
  logic [15:0]        r_target;
  logic [SPEED_W-1:0] r_cruise;
  logic               r_dir;
  logic               r_enc_rst;
  logic               r_done;
  done_status_t       r_status;
  logic               r_fault;
  logic               r_busy;
  logic               r_ready;
  logic [31:0]        r_clr_cnt;
  logic [31:0]        r_stall_cnt;
  logic signed [31:0] r_enc_prev;

  logic [15:0]        w_dist;
  logic [15:0]        w_remaining;
  logic               w_reached;
  logic               w_decel;
  logic               w_enc_moved;
  logic               w_stall;
  logic               w_stop;
  logic               w_clear_end;
  logic               w_zero;
  logic               w_load_min;
  logic               w_up;
  logic               w_down;
  logic [SPEED_W-1:0] w_speed;

  assign w_dist      = sat_dist(encoder_cm);
  assign w_remaining = (r_target > w_dist) ? (r_target - w_dist) : 16'd0;
  assign w_reached   = (w_dist >= r_target);
  assign w_decel     = (w_remaining <= 16'(DECEL_CM));
  assign w_enc_moved = (encoder_cm != r_enc_prev);
  assign w_stall     = !w_enc_moved && (r_stall_cnt == 32'(STALL_TICKS - 1));
  // Priority abort > reached > stall is resolved where the status is chosen.
  assign w_stop      = abort || w_reached || w_stall;
  // Last settle cycle after the encoder reset pulse.
  assign w_clear_end = (r_clr_cnt == 32'(CLEAR_CYCLES + 1));

  // Ramp commands mirror the transitions taken in the sequencer below.
  always_comb begin
    w_zero     = 1'b0;
    w_load_min = 1'b0;
    w_up       = 1'b0;
    w_down     = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        if (!abort && w_clear_end && (r_target != 16'd0))
          w_load_min = 1'b1;
        else
          w_zero = 1'b1;
      end
      ST_RAMP_UP: begin
        if (w_stop)
          w_zero = 1'b1;
        else if (!w_decel && (w_speed < r_cruise))
          w_up = 1'b1;
      end
      ST_CRUISE: begin
        if (w_stop)
          w_zero = 1'b1;
      end
      ST_RAMP_DOWN: begin
        if (w_stop)
          w_zero = 1'b1;
        else
          w_down = 1'b1;
      end
      default: w_zero = 1'b1;
    endcase
  end

  speed_ramp #(
    .RAMP_TICKS (RAMP_TICKS),
    .MIN_SPEED  (MIN_SPEED)
  ) u_speed_ramp (
    .i_clk      (CLOCK_50),
    .i_rst_n    (rst_n),
    .i_zero     (w_zero),
    .i_load_min (w_load_min),
    .i_up       (w_up),
    .i_down     (w_down),
    .i_ceiling  (r_cruise),
    .o_speed    (w_speed)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_target    <= '0;
      r_cruise    <= '0;
      r_dir       <= 1'b0;
      r_enc_rst   <= 1'b0;
      r_done      <= 1'b0;
      r_status    <= DS_REACHED;
      r_fault     <= 1'b0;
      r_busy      <= 1'b0;
      r_ready     <= 1'b0;
      r_clr_cnt   <= '0;
      r_stall_cnt <= '0;
      r_enc_prev  <= '0;
    end else begin
      r_done     <= 1'b0;
      r_enc_prev <= encoder_cm;
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          if (cmd_valid && r_ready) begin
            r_state   <= ST_CLEAR;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
            r_target  <= cmd_distance_cm;
            r_cruise  <= clamp_speed(cmd_speed);
            r_dir     <= cmd_dir;
            r_enc_rst <= 1'b1;
            r_clr_cnt <= '0;
          end
        end

        ST_CLEAR: begin
          if (abort) begin
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
            r_status  <= DS_ABORTED;
            r_enc_rst <= 1'b0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 32'd1;
            if (r_clr_cnt == 32'(CLEAR_CYCLES - 1))
              r_enc_rst <= 1'b0;
            if (w_clear_end) begin
              if (r_target == 16'd0) begin
                r_state  <= ST_DONE;
                r_done   <= 1'b1;
                r_status <= DS_REACHED;
              end else begin
                r_state     <= ST_RAMP_UP;
                r_stall_cnt <= '0;
              end
            end
          end
        end

        ST_RAMP_UP, ST_CRUISE, ST_RAMP_DOWN: begin
          if (w_stop) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            if (abort)
              r_status <= DS_ABORTED;
            else if (w_reached)
              r_status <= DS_REACHED;
            else
              r_status <= DS_STALLED;
          end else begin
            if (w_enc_moved)
              r_stall_cnt <= '0;
            else
              r_stall_cnt <= r_stall_cnt + 32'd1;
            // Every state entry reloads the watchdog.
            if ((r_state != ST_RAMP_DOWN) && w_decel) begin
              r_state     <= ST_RAMP_DOWN;
              r_stall_cnt <= '0;
            end else if ((r_state == ST_RAMP_UP) && (w_speed >= r_cruise)) begin
              r_state     <= ST_CRUISE;
              r_stall_cnt <= '0;
            end
          end
        end

        ST_DONE: begin
          if (r_status == DS_STALLED) begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end

        ST_FAULT: begin
          if (fault_clr) begin
            r_state <= ST_IDLE;
            r_fault <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_fault <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready     = r_ready;
  assign motor_speed   = w_speed;
  assign motor_dir     = r_dir;
  assign encoder_reset = r_enc_rst;
  assign busy          = r_busy;
  assign done          = r_done;
  assign done_status   = r_status;
  assign fault         = r_fault;

endmodule

// File: tb/tb_drive_move_controller.sv
// ----------------------------------------------------------------------------
// tb_drive_move_controller
//   Directed bench for drive_move_controller with a small encoder model
//   (+/-1 cm every 8 cycles while the motor turns, cleared by encoder_reset,
//   optionally frozen or overridden). Outputs are sampled on the falling edge;
//   inputs change on the falling edge.
// ----------------------------------------------------------------------------
module tb_drive_move_controller;

  logic               CLOCK_50 = 1'b0;
  logic               rst_n;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [15:0]        cmd_distance_cm;
  logic [6:0]         cmd_speed;
  logic               cmd_dir;
  logic               abort;
  logic               fault_clr;
  logic signed [31:0] encoder_cm;
  logic [6:0]         motor_speed;
  logic               motor_dir;
  logic               encoder_reset;
  logic               busy;
  logic               done;
  logic [1:0]         done_status;
  logic               fault;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] speed_or = '0;
  logic       done_or  = 1'b0;

  // Encoder model
  logic signed [31:0] enc_model = '0;
  int                 enc_div   = 0;
  logic               enc_freeze = 1'b0;
  logic               ovr_en     = 1'b0;
  logic signed [31:0] ovr_val    = '0;

  assign encoder_cm = ovr_en ? ovr_val : enc_model;

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    if (encoder_reset) begin
      enc_model <= '0;
      enc_div   <= 0;
    end else if ((motor_speed != 7'd0) && !enc_freeze) begin
      if (enc_div == 7) begin
        enc_div   <= 0;
        enc_model <= motor_dir ? (enc_model - 32'sd1) : (enc_model + 32'sd1);
      end else begin
        enc_div <= enc_div + 1;
      end
    end
  end

  drive_move_controller #(
    .RAMP_TICKS   (4),
    .DECEL_CM     (5),
    .MIN_SPEED    (10),
    .MAX_SPEED    (100),
    .STALL_TICKS  (64),
    .CLEAR_CYCLES (4)
  ) dut (
    .CLOCK_50        (CLOCK_50),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_distance_cm (cmd_distance_cm),
    .cmd_speed       (cmd_speed),
    .cmd_dir         (cmd_dir),
    .abort           (abort),
    .fault_clr       (fault_clr),
    .encoder_cm      (encoder_cm),
    .motor_speed     (motor_speed),
    .motor_dir       (motor_dir),
    .encoder_reset   (encoder_reset),
    .busy            (busy),
    .done            (done),
    .done_status     (done_status),
    .fault           (fault)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLOCK_50);
      speed_or = speed_or | motor_speed;
      done_or  = done_or | done;
    end
  endtask

  // Offer a command at a falling edge; returns in the cycle after acceptance.
  task automatic send_cmd(input logic [15:0] d, input logic [6:0] s, input logic dir);
    check_eq("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_distance_cm = d;
    cmd_speed       = s;
    cmd_dir         = dir;
    cmd_valid       = 1'b1;
    cyc(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_enc(input string tag, input logic signed [31:0] v, input int budget);
    int k;
    k = 0;
    while ((enc_model !== v) && (k < budget)) begin
      cyc(1);
      k++;
    end
    check_eq(tag, 32'(enc_model == v), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while ((done !== 1'b1) && (k < budget)) begin
      cyc(1);
      k++;
    end
    check_eq(tag, 32'(done), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n           = 1'b0;
    cmd_valid       = 1'b0;
    cmd_distance_cm = '0;
    cmd_speed       = '0;
    cmd_dir         = 1'b0;
    abort           = 1'b0;
    fault_clr       = 1'b0;

    // ---- reset values ----
    cyc(3);
    check_eq("rst_speed",  32'(motor_speed),   32'd0);
    check_eq("rst_dir",    32'(motor_dir),     32'd0);
    check_eq("rst_encrst", 32'(encoder_reset), 32'd0);
    check_eq("rst_done",   32'(done),          32'd0);
    check_eq("rst_status", 32'(done_status),   32'd0);
    check_eq("rst_fault",  32'(fault),         32'd0);
    check_eq("rst_busy",   32'(busy),          32'd0);
    rst_n = 1'b1;
    cyc(1);
    check_eq("post_rst_ready", 32'(cmd_ready), 32'd1);

    // ---- move to 30 cm at speed 14 ----
    send_cmd(16'd30, 7'd14, 1'b0);                            // N+1
    check_eq("t1_encrst_first", 32'(encoder_reset), 32'd1);
    check_eq("t1_busy",         32'(busy),          32'd1);
    check_eq("t1_ready_low",    32'(cmd_ready),     32'd0);
    cyc(3);                                                   // N+4
    check_eq("t1_encrst_last",  32'(encoder_reset), 32'd1);
    cyc(1);                                                   // N+5
    check_eq("t1_encrst_off",   32'(encoder_reset), 32'd0);
    cyc(1);                                                   // N+6
    check_eq("t1_speed_settle", 32'(motor_speed),   32'd0);
    cyc(1);                                                   // N+7
    check_eq("t1_speed10",      32'(motor_speed),   32'd10);
    cyc(3);                                                   // N+10
    check_eq("t1_speed10_hold", 32'(motor_speed),   32'd10);
    cyc(1);
    check_eq("t1_speed11",      32'(motor_speed),   32'd11);
    cyc(4);
    check_eq("t1_speed12",      32'(motor_speed),   32'd12);
    cyc(4);
    check_eq("t1_speed13",      32'(motor_speed),   32'd13);
    cyc(4);
    check_eq("t1_speed14",      32'(motor_speed),   32'd14);
    wait_enc("t1_wait_dist25", 32'sd25, 400);                 // P+1
    check_eq("t1_cruise14",     32'(motor_speed),   32'd14);
    cyc(4);
    check_eq("t1_decel_hold",   32'(motor_speed),   32'd14);
    cyc(1);
    check_eq("t1_decel13",      32'(motor_speed),   32'd13);
    wait_enc("t1_wait_dist30", 32'sd30, 200);                 // Q+1
    check_eq("t1_floor10",      32'(motor_speed),   32'd10);
    check_eq("t1_done_early",   32'(done),          32'd0);
    cyc(1);
    check_eq("t1_done",         32'(done),          32'd1);
    check_eq("t1_status",       32'(done_status),   32'd0);
    check_eq("t1_stop_speed",   32'(motor_speed),   32'd0);
    cyc(1);
    check_eq("t1_done_pulse",   32'(done),          32'd0);
    check_eq("t1_ready_back",   32'(cmd_ready),     32'd1);
    check_eq("t1_busy_off",     32'(busy),          32'd0);

    // ---- speed 120 clamps to 100, then abort in cruise ----
    send_cmd(16'd1000, 7'd120, 1'b1);
    check_eq("t3_dir",          32'(motor_dir),     32'd1);
    cyc(365);                                                 // N+366
    check_eq("t3_speed99",      32'(motor_speed),   32'd99);
    cyc(1);
    check_eq("t3_speed100",     32'(motor_speed),   32'd100);
    cyc(20);
    check_eq("t3_clamp100",     32'(motor_speed),   32'd100);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    check_eq("ab_speed0",       32'(motor_speed),   32'd0);
    check_eq("ab_done",         32'(done),          32'd1);
    check_eq("ab_status",       32'(done_status),   32'd1);
    cyc(1);
    check_eq("ab_ready",        32'(cmd_ready),     32'd1);
    check_eq("ab_status_held",  32'(done_status),   32'd1);

    // ---- target 0 ----
    speed_or = '0;
    send_cmd(16'd0, 7'd14, 1'b0);                             // N+1
    check_eq("t0_encrst",       32'(encoder_reset), 32'd1);
    cyc(3);
    check_eq("t0_encrst_last",  32'(encoder_reset), 32'd1);
    cyc(1);
    check_eq("t0_encrst_off",   32'(encoder_reset), 32'd0);
    cyc(1);
    check_eq("t0_no_done_yet",  32'(done),          32'd0);
    cyc(1);                                                   // N+7
    check_eq("t0_done",         32'(done),          32'd1);
    check_eq("t0_status",       32'(done_status),   32'd0);
    cyc(1);
    check_eq("t0_ready",        32'(cmd_ready),     32'd1);
    check_eq("t0_speed_never",  32'(speed_or),      32'd0);

    // ---- speed 3 holds at 10, reverse direction ----
    send_cmd(16'd30, 7'd3, 1'b1);
    cyc(6);
    check_eq("t3b_speed10",     32'(motor_speed),   32'd10);
    cyc(20);
    check_eq("t3b_hold10",      32'(motor_speed),   32'd10);
    wait_done("t3b_wait_done", 400);
    check_eq("t3b_status",      32'(done_status),   32'd0);
    check_eq("t3b_enc",         32'(enc_model),     32'hFFFF_FFE2);
    cyc(1);

    // ---- stalled encoder ----
    enc_freeze = 1'b1;
    send_cmd(16'd30, 7'd12, 1'b0);                            // N+1
    cyc(78);                                                  // N+79
    check_eq("st_no_done",      32'(done),          32'd0);
    check_eq("st_speed12",      32'(motor_speed),   32'd12);
    cyc(1);                                                   // N+80
    check_eq("st_done",         32'(done),          32'd1);
    check_eq("st_status",       32'(done_status),   32'd2);
    check_eq("st_speed0",       32'(motor_speed),   32'd0);
    cyc(1);
    check_eq("st_fault",        32'(fault),         32'd1);
    check_eq("st_busy",         32'(busy),          32'd1);
    check_eq("st_ready_low",    32'(cmd_ready),     32'd0);
    cmd_distance_cm = 16'd0;
    cmd_valid       = 1'b1;
    cyc(2);
    cmd_valid = 1'b0;
    check_eq("st_cmd_ignored",  32'(fault),         32'd1);
    check_eq("st_encrst_idle",  32'(encoder_reset), 32'd0);
    fault_clr = 1'b1;
    cyc(1);
    fault_clr  = 1'b0;
    enc_freeze = 1'b0;
    check_eq("fc_fault_off",    32'(fault),         32'd0);
    check_eq("fc_ready",        32'(cmd_ready),     32'd1);
    check_eq("fc_busy_off",     32'(busy),          32'd0);

    // ---- reset during ramp up ----
    send_cmd(16'd30, 7'd14, 1'b1);
    check_eq("rr_dir",          32'(motor_dir),     32'd1);
    cyc(10);                                                  // N+11
    check_eq("rr_speed11",      32'(motor_speed),   32'd11);
    done_or = 1'b0;
    rst_n   = 1'b0;
    cyc(1);
    check_eq("rr_speed",        32'(motor_speed),   32'd0);
    check_eq("rr_dir0",         32'(motor_dir),     32'd0);
    check_eq("rr_encrst",       32'(encoder_reset), 32'd0);
    check_eq("rr_status",       32'(done_status),   32'd0);
    check_eq("rr_fault",        32'(fault),         32'd0);
    check_eq("rr_busy",         32'(busy),          32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    check_eq("rr_no_done",      32'(done_or),       32'd0);
    check_eq("rr_ready",        32'(cmd_ready),     32'd1);

    // ---- new command after reset; saturated encoder distance ends it ----
    send_cmd(16'hFFFF, 7'd3, 1'b0);                           // N+1
    check_eq("sat_busy",        32'(busy),          32'd1);
    cyc(9);                                                   // N+10
    check_eq("sat_speed10",     32'(motor_speed),   32'd10);
    ovr_val = 32'shFFFE_0000;
    ovr_en  = 1'b1;
    cyc(1);
    check_eq("sat_done",        32'(done),          32'd1);
    check_eq("sat_status",      32'(done_status),   32'd0);
    check_eq("sat_speed0",      32'(motor_speed),   32'd0);
    ovr_en = 1'b0;
    cyc(1);
    check_eq("sat_ready",       32'(cmd_ready),     32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
